// File: rtl/ni_vc_send_dma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ni_vc_send_dma_pkg
// Purpose  : Shared NI definitions for the send DMA and the NI register bank:
//            flit header bit positions, head-flit field LSBs and the send-FSM
//            state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ni_vc_send_dma_pkg;

    // Flit header: bit 1 marks a head flit, bit 0 marks a tail flit.
    localparam int HDR_HEAD_BIT    = 1;
    localparam int HDR_TAIL_BIT    = 0;

    // Head-flit payload field LSB positions.
    localparam int FLIT_DEST_LSB   = 0;
    localparam int FLIT_CLASS_LSB  = 16;
    localparam int FLIT_WEIGHT_LSB = 24;

    typedef enum logic [1:0] {
        SEND_IDLE = 2'd0,
        SEND_HEAD = 2'd1,
        SEND_RD   = 2'd2,
        SEND_BODY = 2'd3
    } send_state_e;

endpackage : ni_vc_send_dma_pkg
`default_nettype wire

// File: rtl/ni_vc_send_dma_if.sv
`default_nettype none
// ============================================================================
// Module   : ni_vc_send_dma_if
// Purpose  : Bundles the send DMA's Wishbone read-master bus and its flit
//            output handshake.
// Ports    : m_adr_o/m_cyc_o/m_stb_o/m_we_o (master -> slave), m_dat_i/m_ack_i
//            (slave -> master), flit_valid/flit_hdr/flit_dat (master -> sink),
//            flit_ready (sink -> master).
//            modport master : the DMA side; modport slave : memory/flit sink.
// Revision : 1.0 - initial release
// ============================================================================
interface ni_vc_send_dma_if #(
    parameter int Dw = 32
);
    logic [Dw-1:0] m_adr_o;
    logic          m_cyc_o;
    logic          m_stb_o;
    logic          m_we_o;
    logic [Dw-1:0] m_dat_i;
    logic          m_ack_i;

    logic          flit_valid;
    logic          flit_ready;
    logic [1:0]    flit_hdr;
    logic [Dw-1:0] flit_dat;

    modport master (
        output m_adr_o, m_cyc_o, m_stb_o, m_we_o,
        input  m_dat_i, m_ack_i,
        output flit_valid, flit_hdr, flit_dat,
        input  flit_ready
    );

    modport slave (
        input  m_adr_o, m_cyc_o, m_stb_o, m_we_o,
        output m_dat_i, m_ack_i,
        input  flit_valid, flit_hdr, flit_dat,
        output flit_ready
    );
endinterface : ni_vc_send_dma_if
`default_nettype wire

// File: rtl/ni_vc_send_dma.sv
`default_nettype none
// ============================================================================
// Module   : ni_vc_send_dma
// Purpose  : NI virtual-channel send DMA. On send_start it emits a head flit
//            built from the latched destination/class/weight, then for each
//            payload word performs one Wishbone read and forwards the word as
//            a body flit; the last body flit (or the head, for an empty
//            packet) carries the tail bit.
// Ports    : clk, reset (async, active-high)
//            send_start, send_start_addr, send_data_size, dest_e_addr,
//            pck_class, weight  - request fields from the NI register bank
//            send_fsm_is_ideal  - high while the FSM is idle
//            send_done          - one-cycle pulse after tail-flit acceptance
//            bus                - Wishbone read master + flit output
// Revision : 1.0 - initial release
// ============================================================================
module ni_vc_send_dma
    import ni_vc_send_dma_pkg::*;
#(
    parameter  int MAX_TRANSACTION_WIDTH = 10,
    parameter  int Dw                    = 32,
    parameter  int EAw                   = 4,
    parameter  int C                     = 4,
    parameter  int WEIGHTw               = 4,
    localparam int Cw                    = (C > 1) ? $clog2(C) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             send_start,
    input  logic [Dw-1:0]                    send_start_addr,
    input  logic [MAX_TRANSACTION_WIDTH-1:0] send_data_size,
    input  logic [EAw-1:0]                   dest_e_addr,
    input  logic [Cw-1:0]                    pck_class,
    input  logic [WEIGHTw-1:0]               weight,
    output logic                             send_fsm_is_ideal,
    output logic                             send_done,
    ni_vc_send_dma_if.master                 bus
);

    send_state_e                      state_q;
    logic [Dw-1:0]                    addr_q;
    logic [MAX_TRANSACTION_WIDTH-1:0] remaining_q;
    logic [Dw-1:0]                    data_q;
    logic [EAw-1:0]                   dest_q;
    logic [Cw-1:0]                    class_q;
    logic [WEIGHTw-1:0]               weight_q;
    logic                             flit_valid_q;
    logic [1:0]                       flit_hdr_q;
    logic                             cyc_q;
    logic                             done_q;
    logic [Dw-1:0]                    head_word;

    localparam logic [MAX_TRANSACTION_WIDTH-1:0] c_ONE = MAX_TRANSACTION_WIDTH'(1);

    always_comb begin
        head_word                                 = '0;
        head_word[FLIT_DEST_LSB   +: EAw]         = dest_q;
        head_word[FLIT_CLASS_LSB  +: Cw]          = class_q;
        head_word[FLIT_WEIGHT_LSB +: WEIGHTw]     = weight_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= SEND_IDLE;
            addr_q       <= '0;
            remaining_q  <= '0;
            data_q       <= '0;
            dest_q       <= '0;
            class_q      <= '0;
            weight_q     <= '0;
            flit_valid_q <= 1'b0;
            flit_hdr_q   <= 2'b00;
            cyc_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                SEND_IDLE: begin
                    if (send_start) begin
                        addr_q                   <= send_start_addr;
                        remaining_q              <= send_data_size;
                        dest_q                   <= dest_e_addr;
                        class_q                  <= pck_class;
                        weight_q                 <= weight;
                        flit_valid_q             <= 1'b1;
                        flit_hdr_q               <= 2'b00;
                        flit_hdr_q[HDR_HEAD_BIT] <= 1'b1;
                        flit_hdr_q[HDR_TAIL_BIT] <= (send_data_size == '0);
                        state_q                  <= SEND_HEAD;
                    end
                end
                SEND_HEAD: begin
                    if (bus.flit_ready) begin
                        flit_valid_q <= 1'b0;
                        flit_hdr_q   <= 2'b00;
                        if (remaining_q == '0) begin
                            done_q  <= 1'b1;
                            state_q <= SEND_IDLE;
                        end else begin
                            cyc_q   <= 1'b1;
                            state_q <= SEND_RD;
                        end
                    end
                end
                SEND_RD: begin
                    // Single-beat read: the request drops right after the ack.
                    if (bus.m_ack_i) begin
                        data_q                   <= bus.m_dat_i;
                        cyc_q                    <= 1'b0;
                        flit_valid_q             <= 1'b1;
                        flit_hdr_q               <= 2'b00;
                        flit_hdr_q[HDR_TAIL_BIT] <= (remaining_q == c_ONE);
                        state_q                  <= SEND_BODY;
                    end
                end
                SEND_BODY: begin
                    if (bus.flit_ready) begin
                        addr_q       <= addr_q + Dw'(1);
                        remaining_q  <= remaining_q - c_ONE;
                        flit_valid_q <= 1'b0;
                        flit_hdr_q   <= 2'b00;
                        if (remaining_q == c_ONE) begin
                            done_q  <= 1'b1;
                            state_q <= SEND_IDLE;
                        end else begin
                            cyc_q   <= 1'b1;
                            state_q <= SEND_RD;
                        end
                    end
                end
                default: state_q <= SEND_IDLE;
            endcase
        end
    end

    // Payload is selected from registers only, so it cannot change while a
    // flit is waiting for flit_ready.
    always_comb begin
        case (state_q)
            SEND_HEAD: bus.flit_dat = head_word;
            SEND_BODY: bus.flit_dat = data_q;
            default:   bus.flit_dat = '0;
        endcase
    end

    assign bus.flit_valid    = flit_valid_q;
    assign bus.flit_hdr      = flit_hdr_q;
    assign bus.m_adr_o       = addr_q;
    assign bus.m_cyc_o       = cyc_q;
    assign bus.m_stb_o       = cyc_q;
    assign bus.m_we_o        = 1'b0;
    assign send_done         = done_q;
    assign send_fsm_is_ideal = (state_q == SEND_IDLE);

endmodule : ni_vc_send_dma
`default_nettype wire

// File: tb/tb_ni_vc_send_dma.sv
`default_nettype none
// ============================================================================
// Module   : tb_ni_vc_send_dma
// Purpose  : Self-checking bench for ni_vc_send_dma with a packet-level
//            reference model (expected flit list and read-address list).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ni_vc_send_dma;

    logic        clk;
    logic        reset;
    logic        send_start;
    logic [31:0] send_start_addr;
    logic [9:0]  send_data_size;
    logic [3:0]  dest_e_addr;
    logic [1:0]  pck_class;
    logic [3:0]  weight;
    logic        send_fsm_is_ideal;
    logic        send_done;

    int errors = 0;
    int checks = 0;

    logic [33:0] exp_flits[$];
    logic [31:0] exp_rds[$];
    logic [33:0] obs_flits[$];
    logic [31:0] obs_rds[$];
    int done_cnt, stab_viol, lat_viol, first_valid_cyc;
    bit timed_out;

    ni_vc_send_dma_if #(.Dw(32)) bus ();

    ni_vc_send_dma #(
        .MAX_TRANSACTION_WIDTH(10), .Dw(32), .EAw(4), .C(4), .WEIGHTw(4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .send_start       (send_start),
        .send_start_addr  (send_start_addr),
        .send_data_size   (send_data_size),
        .dest_e_addr      (dest_e_addr),
        .pck_class        (pck_class),
        .weight           (weight),
        .send_fsm_is_ideal(send_fsm_is_ideal),
        .send_done        (send_done),
        .bus              (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents seen by the Wishbone slave model.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ a[15:0]} + 32'h0101_0101;
    endfunction

    // Reference model: the packet a request must produce.
    task automatic build_expected(input logic [31:0] a, input int sz, input logic [3:0] d,
                                  input logic [1:0] c, input logic [3:0] w);
        logic [31:0] ra;
        exp_flits.delete();
        exp_rds.delete();
        exp_flits.push_back({(sz == 0) ? 2'b11 : 2'b10,
                             32'(d) + (32'(c) << 16) + (32'(w) << 24)});
        for (int i = 0; i < sz; i++) begin
            ra = a + 32'(i);
            exp_rds.push_back(ra);
            exp_flits.push_back({(i == sz - 1) ? 2'b01 : 2'b00, mem_word(ra)});
        end
    endtask

    // Drives one request and acts as memory slave and flit sink until the
    // packet completes (plus a few idle cycles). rmode: 0 always ready,
    // 1 random ready, 2 ready held low 5 valid cycles per flit.
    task automatic run_packet(input logic [31:0] a, input int sz, input logic [3:0] d,
                              input logic [1:0] c, input logic [3:0] w,
                              input int rmode, input int ack_max, input bit perturb);
        int stall, wait_n, post;
        bit ack_prev, prev_hold, perturbed;
        logic [34:0] prev_out;
        obs_flits.delete();
        obs_rds.delete();
        done_cnt = 0; stab_viol = 0; lat_viol = 0; first_valid_cyc = -1; timed_out = 0;
        stall = 5; wait_n = $urandom_range(0, ack_max); post = 0;
        ack_prev = 0; prev_hold = 0; perturbed = 0; prev_out = '0;
        @(negedge clk);
        send_start = 1'b1; send_start_addr = a; send_data_size = 10'(sz);
        dest_e_addr = d; pck_class = c; weight = w;
        bus.flit_ready = 1'b0; bus.m_ack_i = 1'b0;
        for (int n = 1; n <= 600 && post < 3; n++) begin
            @(negedge clk);
            send_start = 1'b0;
            if (bus.flit_valid && first_valid_cyc < 0) first_valid_cyc = n;
            if (ack_prev && !bus.flit_valid) lat_viol++;
            if (prev_hold && prev_out !== {bus.flit_valid, bus.flit_hdr, bus.flit_dat}) stab_viol++;
            if (send_done) done_cnt++;
            if (done_cnt > 0) post++;
            if (perturb && !perturbed && bus.flit_valid && !bus.flit_hdr[1]) begin
                send_start = 1'b1; send_start_addr = 32'hDEAD_BEE0; send_data_size = 10'd9;
                dest_e_addr = 4'hF; pck_class = 2'd3; weight = 4'hF; perturbed = 1;
            end
            case (rmode)
                0:       bus.flit_ready = 1'b1;
                1:       bus.flit_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (bus.flit_valid && stall > 0) begin
                        bus.flit_ready = 1'b0;
                        stall--;
                    end else begin
                        bus.flit_ready = bus.flit_valid;
                    end
                end
            endcase
            if (bus.flit_valid && bus.flit_ready) begin
                obs_flits.push_back({bus.flit_hdr, bus.flit_dat});
                stall = 5;
            end
            prev_hold = bus.flit_valid && !bus.flit_ready;
            prev_out  = {bus.flit_valid, bus.flit_hdr, bus.flit_dat};
            if (bus.m_cyc_o && bus.m_stb_o) begin
                if (wait_n == 0) begin
                    bus.m_ack_i = 1'b1;
                    bus.m_dat_i = mem_word(bus.m_adr_o);
                    obs_rds.push_back(bus.m_adr_o);
                    wait_n = $urandom_range(0, ack_max);
                end else begin
                    bus.m_ack_i = 1'b0;
                    wait_n--;
                end
            end else begin
                bus.m_ack_i = 1'b0;
            end
            ack_prev = bus.m_ack_i;
        end
        if (post < 3) timed_out = 1;
        bus.flit_ready = 1'b0;
        bus.m_ack_i    = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.flit_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", bus.flit_valid); end
        checks++; if (bus.m_cyc_o !== 1'b0) begin errors++; $display("FAIL rst_cyc got %b want 0", bus.m_cyc_o); end
        checks++; if (bus.m_stb_o !== 1'b0) begin errors++; $display("FAIL rst_stb got %b want 0", bus.m_stb_o); end
        checks++; if (bus.m_we_o !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", bus.m_we_o); end
        checks++; if (send_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", send_done); end
        checks++; if (send_fsm_is_ideal !== 1'b1) begin errors++; $display("FAIL rst_ideal got %b want 1", send_fsm_is_ideal); end
        checks++; if (bus.m_adr_o !== 32'h0) begin errors++; $display("FAIL rst_adr got %h want 0", bus.m_adr_o); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (send_fsm_is_ideal !== 1'b1 || bus.flit_valid !== 1'b0) begin
            errors++; $display("FAIL post_rst_idle got ideal=%b valid=%b want 1/0", send_fsm_is_ideal, bus.flit_valid);
        end
    endtask

    task automatic test_single_flit;
        run_packet(32'h0000_0040, 0, 4'd3, 2'd1, 4'd2, 0, 0, 0);
        checks++; if (obs_flits.size() !== 1) begin errors++; $display("FAIL single_count got %0d want 1", obs_flits.size()); end
        checks++; if (obs_flits.size() > 0 && obs_flits[0] !== {2'b11, 32'h0201_0003}) begin
            errors++; $display("FAIL single_flit got %h want %h", obs_flits[0], {2'b11, 32'h0201_0003});
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL single_done got %0d want 1", done_cnt); end
        checks++; if (first_valid_cyc !== 1) begin errors++; $display("FAIL single_latency got %0d want 1", first_valid_cyc); end
        checks++; if (obs_rds.size() !== 0) begin errors++; $display("FAIL single_reads got %0d want 0", obs_rds.size()); end
    endtask

    task automatic test_burst;
        build_expected(32'h100, 3, 4'd5, 2'd2, 4'd7);
        run_packet(32'h100, 3, 4'd5, 2'd2, 4'd7, 0, 0, 0);
        checks++; if (obs_flits.size() !== 4) begin errors++; $display("FAIL burst_count got %0d want 4", obs_flits.size()); end
        for (int i = 0; i < 4 && i < obs_flits.size(); i++) begin
            checks++; if (obs_flits[i] !== exp_flits[i]) begin errors++; $display("FAIL burst_flit%0d got %h want %h", i, obs_flits[i], exp_flits[i]); end
        end
        for (int i = 0; i < 3; i++) begin
            checks++; if (i >= obs_rds.size() || obs_rds[i] !== 32'h100 + 32'(i)) begin
                errors++; $display("FAIL burst_adr%0d got %h want %h", i, (i < obs_rds.size()) ? obs_rds[i] : 32'hX, 32'h100 + 32'(i));
            end
        end
        checks++; if (done_cnt !== 1 || lat_viol !== 0 || timed_out) begin
            errors++; $display("FAIL burst_done_lat got done=%0d lat=%0d to=%0d want 1/0/0", done_cnt, lat_viol, timed_out);
        end
    endtask

    task automatic test_backpressure;
        build_expected(32'h2000, 3, 4'd9, 2'd3, 4'd1);
        run_packet(32'h2000, 3, 4'd9, 2'd3, 4'd1, 2, 0, 0);
        checks++; if (stab_viol !== 0) begin errors++; $display("FAIL bp_stable got %0d want 0", stab_viol); end
        checks++; if (obs_rds.size() !== 3) begin errors++; $display("FAIL bp_reads got %0d want 3", obs_rds.size()); end
        checks++; if (obs_flits !== exp_flits) begin errors++; $display("FAIL bp_flits got %0d flits want %0d matching", obs_flits.size(), exp_flits.size()); end
        checks++; if (done_cnt !== 1 || timed_out) begin errors++; $display("FAIL bp_done got %0d to=%0d want 1", done_cnt, timed_out); end
    endtask

    task automatic test_start_during_body;
        build_expected(32'h300, 4, 4'd6, 2'd0, 4'd3);
        run_packet(32'h300, 4, 4'd6, 2'd0, 4'd3, 1, 2, 1);
        checks++; if (obs_flits !== exp_flits) begin errors++; $display("FAIL perturb_flits got %0d flits want %0d matching", obs_flits.size(), exp_flits.size()); end
        checks++; if (obs_rds !== exp_rds) begin errors++; $display("FAIL perturb_reads got %0d reads want %0d matching", obs_rds.size(), exp_rds.size()); end
        checks++; if (done_cnt !== 1 || timed_out) begin errors++; $display("FAIL perturb_done got %0d to=%0d want 1", done_cnt, timed_out); end
    endtask

    task automatic test_reset_mid;
        bit seen;
        int done_seen;
        seen = 0; done_seen = 0;
        @(negedge clk);
        send_start = 1'b1; send_start_addr = 32'h200; send_data_size = 10'd3;
        dest_e_addr = 4'd1; pck_class = 2'd1; weight = 4'd1;
        bus.flit_ready = 1'b1; bus.m_ack_i = 1'b0;
        @(negedge clk);
        send_start = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            if (bus.m_cyc_o) seen = 1;
            else @(negedge clk);
        end
        checks++; if (!seen) begin errors++; $display("FAIL rstmid_cyc got 0 want 1"); end
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.m_cyc_o !== 1'b0 || bus.m_stb_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_wb got cyc=%b stb=%b want 0/0", bus.m_cyc_o, bus.m_stb_o);
        end
        checks++; if (bus.flit_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", bus.flit_valid); end
        checks++; if (send_fsm_is_ideal !== 1'b1) begin errors++; $display("FAIL rstmid_ideal got %b want 1", send_fsm_is_ideal); end
        repeat (2) begin @(negedge clk); if (send_done) done_seen++; end
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (send_done) done_seen++;
            if (bus.flit_valid || bus.m_cyc_o) done_seen++;
        end
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL rstmid_quiet got %0d want 0", done_seen); end
        bus.flit_ready = 1'b0;
    endtask

    task automatic test_addr_wrap;
        build_expected(32'hFFFF_FFFF, 2, 4'd2, 2'd2, 4'd2);
        run_packet(32'hFFFF_FFFF, 2, 4'd2, 2'd2, 4'd2, 0, 1, 0);
        checks++; if (obs_rds.size() !== 2 || obs_rds[0] !== 32'hFFFF_FFFF || obs_rds[1] !== 32'h0) begin
            errors++; $display("FAIL wrap_reads got n=%0d first=%h second=%h want FFFFFFFF/00000000",
                               obs_rds.size(), (obs_rds.size() > 0) ? obs_rds[0] : 32'hX, (obs_rds.size() > 1) ? obs_rds[1] : 32'hX);
        end
        checks++; if (obs_flits !== exp_flits) begin errors++; $display("FAIL wrap_flits got %0d flits want %0d matching", obs_flits.size(), exp_flits.size()); end
        checks++; if (done_cnt !== 1 || timed_out) begin errors++; $display("FAIL wrap_done got %0d to=%0d want 1", done_cnt, timed_out); end
    endtask

    task automatic test_random;
        logic [31:0] a;
        int sz;
        logic [3:0] d, w;
        logic [1:0] c;
        for (int k = 0; k < 15; k++) begin
            a  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
            sz = $urandom_range(0, 6);
            d  = 4'($urandom); c = 2'($urandom); w = 4'($urandom);
            build_expected(a, sz, d, c, w);
            run_packet(a, sz, d, c, w, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            checks++; if (obs_flits !== exp_flits || obs_rds !== exp_rds) begin
                errors++; $display("FAIL rand%0d_packet got flits=%0d reads=%0d want flits=%0d reads=%0d",
                                   k, obs_flits.size(), obs_rds.size(), exp_flits.size(), exp_rds.size());
            end
            checks++; if (done_cnt !== 1 || timed_out || stab_viol !== 0 || lat_viol !== 0 || first_valid_cyc !== 1) begin
                errors++; $display("FAIL rand%0d_timing got done=%0d to=%0d stab=%0d lat=%0d first=%0d want 1/0/0/0/1",
                                   k, done_cnt, timed_out, stab_viol, lat_viol, first_valid_cyc);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        send_start = 1'b0; send_start_addr = '0; send_data_size = '0;
        dest_e_addr = '0; pck_class = '0; weight = '0;
        bus.flit_ready = 1'b0; bus.m_ack_i = 1'b0; bus.m_dat_i = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_single_flit();
        test_burst();
        test_backpressure();
        test_start_during_body();
        test_reset_mid();
        test_addr_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ni_vc_send_dma
`default_nettype wire
